mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter for the single shared memory port. It sits between the core's instruction-fetch path and load/store path on one side, and the unified instruction/data memory on the other. It serializes accesses with round-robin priority, tracks one outstanding transaction, routes the response back to its owner, and aborts transactions the memory never answers.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles spent in WAIT before abort; 0 disables the timeout
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request; held with its payload until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  one-cycle pulse: fetch payload accepted
- if_rvalid_o / if_err_o  out  1 / 1  fetch response valid / error
- if_rdata_o  out  DATA_W  fetch data
- d_req_i, d_we_i  in  1, 1  data request, write enable
- d_be_i  in  4  byte enables
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_gnt_o, d_rvalid_o, d_err_o  out  1 each  same meaning as the fetch side
- d_rdata_o  out  DATA_W  load data
- mem_req_o, mem_we_o  out  1, 1  memory request, write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_gnt_i, mem_rvalid_i, mem_err_i  in  1 each  memory accept, response valid, response error
- mem_rdata_i  in  DATA_W  memory read data
- mem_abort_o  out  1  one-cycle pulse on timeout
- busy_o  out  1  state != IDLE

## Operation
- FSM states are IDLE, ISSUE, and WAIT.
- **IDLE**
  - If any request is pending, pick the winner.
  - Latch the winner's payload (addr, we, be, wdata; fetch uses we=0, be=4'hF) and record the owner.
  - Pulse the winner's gnt_o combinationally in this cycle, then go to ISSUE.
  - mem_req_o=0.
- **Arbitration**
  - With a single requester, that requester wins.
  - When both request, the requester that is not last_owner wins (round-robin).
  - last_owner updates on every grant.
- **ISSUE**
  - Drive mem_req_o=1 with the latched payload; the payload is stable until mem_gnt_i.
  - On mem_gnt_i, go to WAIT and clear the timeout counter.
  - If mem_gnt_i and mem_rvalid_i arrive in the same cycle, complete directly and go to IDLE.
- **WAIT**
  - mem_req_o=0; the counter increments each cycle.
  - On mem_rvalid_i, complete and go to IDLE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without mem_rvalid_i, pulse mem_abort_o, complete with err=1 and rdata=0, and go to IDLE.
- **Completion**
  - Next cycle, the owner's rvalid_o=1 for exactly one cycle, with rdata_o=mem_rdata_i and err_o=mem_err_i (registered).
  - The non-owner's rvalid_o stays 0.
  - rdata_o/err_o hold their value until the next completion for that port.
- mem_rvalid_i is ignored in IDLE, and in ISSUE without mem_gnt_i; this covers a late response after an abort.
- Timeout counter width is $clog2(TIMEOUT+1) bits and it never wraps.
- Requesters must not change payload while req_i=1 and gnt_o=0. Dropping req_i before gnt is legal; the request is withdrawn.

## Timing
- Reset values (async, rst=0):
  - state=IDLE, last_owner=fetch (first contention therefore goes to data), counter=0.
  - All outputs 0, including rdata_o registers and mem_* payload registers.
- Reset mid-transaction drops mem_req_o immediately (asynchronously) and produces no response.
- Minimum latency, request to rvalid_o:
  - 3 cycles when mem_gnt_i and mem_rvalid_i arrive in the ISSUE cycle (IDLE, ISSUE, response cycle).
  - +1 per memory grant-wait cycle and per response-wait cycle.
- Throughput is one transaction per 2 cycles at best; no request is accepted outside IDLE.
- gnt_o is combinational from req_i and state. Every other output is registered or decoded from state.
- Timeout abort occurs TIMEOUT cycles after the mem_gnt_i cycle. rvalid_o with err=1 follows one cycle after mem_abort_o.

## Test plan
- **Single fetch, zero-latency memory:** if_req_i=1, addr=0x100; mem_gnt_i=1 and mem_rvalid_i=1 with rdata=0xDEADBEEF in ISSUE.
  - Expect if_gnt_o in cycle 0 and mem_req_o in cycle 1.
  - Expect if_rvalid_o=1 with if_rdata_o=0xDEADBEEF in cycle 2, and d_rvalid_o=0.
- **Contention after reset:** both requests held high.
  - Expect grant order data, fetch, data, fetch (first grant to data).
  - Each requester gets its own data back, with no cross-routing.
- **Store:** d_we_i=1, be=4'b0011, addr=0x2004, wdata=0x1234ABCD; mem_gnt_i delayed 3 cycles.
  - mem_* outputs hold these values through every ISSUE cycle.
  - d_rvalid_o pulses once.
- **Timeout:** TIMEOUT=4, memory never asserts mem_rvalid_i.
  - Expect mem_abort_o 4 cycles after the gnt cycle, then d_rvalid_o=1, d_err_o=1, d_rdata_o=0.
  - A late mem_rvalid_i in IDLE produces no rvalid_o.
- **Memory error:** mem_err_i=1 with mem_rvalid_i on a fetch.
  - Expect if_err_o=1 and if_rvalid_o=1.
  - The next fetch (mem_err_i=0) returns if_err_o=0.
- **Async reset during WAIT:** drive rst=0 between clock edges.
  - busy_o and mem_req_o go 0 immediately.
  - No rvalid_o after release.
  - First contention after release grants data.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between fetch and load/store for one memory port.
// One transaction in flight, response routed back to its owner, stalled replies aborted.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic              if_err_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_be_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic              d_err_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic              mem_err_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_abort_o,
  output logic              busy_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CSAT = {CW{1'b1}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          last_d;
  logic          own_d;
  logic          idle;
  logic          pick_d;
  logic          pick_f;
  logic          hit;
  logic          tmo;
  logic          done;

  // Grant selection: the side that did not win last time takes a tie
  always_comb begin
    idle     = (state == S_IDLE);
    pick_d   = d_req_i & (~if_req_i | ~last_d);
    pick_f   = if_req_i & ~pick_d;
    if_gnt_o = idle & pick_f;
    d_gnt_o  = idle & pick_d;
  end

  // Completion detection: normal reply or watchdog expiry in WAIT
  always_comb begin
    hit = ((state == S_ISSUE) & mem_gnt_i & mem_rvalid_i)
        | ((state == S_WAIT) & mem_rvalid_i);
    tmo = (TIMEOUT != 0) & (state == S_WAIT)
        & (cnt == CMAX) & ~mem_rvalid_i;
    done        = hit | tmo;
    mem_abort_o = tmo;
    mem_req_o   = (state == S_ISSUE);
    busy_o      = (state != S_IDLE);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pick_d | pick_f) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (mem_gnt_i) state_nxt = mem_rvalid_i ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and saturating wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_ISSUE) begin
        cnt <= '0;
      end else if (state == S_WAIT && cnt != CSAT) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Payload latch and ownership on every grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'h0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      own_d       <= 1'b0;
      last_d      <= 1'b0;
    end else if (d_gnt_o) begin
      mem_we_o    <= d_we_i;
      mem_be_o    <= d_be_i;
      mem_addr_o  <= d_addr_i;
      mem_wdata_o <= d_wdata_i;
      own_d       <= 1'b1;
      last_d      <= 1'b1;
    end else if (if_gnt_o) begin
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'hF;
      mem_addr_o  <= if_addr_i;
      mem_wdata_o <= '0;
      own_d       <= 1'b0;
      last_d      <= 1'b0;
    end
  end

  // Registered response routed to the owner; data and error hold between replies
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid_o <= 1'b0;
      if_err_o    <= 1'b0;
      if_rdata_o  <= '0;
      d_rvalid_o  <= 1'b0;
      d_err_o     <= 1'b0;
      d_rdata_o   <= '0;
    end else begin
      if_rvalid_o <= done & ~own_d;
      d_rvalid_o  <= done & own_d;
      if (done & ~own_d) begin
        if_err_o   <= tmo | mem_err_i;
        if_rdata_o <= tmo ? '0 : mem_rdata_i;
      end
      if (done & own_d) begin
        d_err_o   <= tmo | mem_err_i;
        d_rdata_o <= tmo ? '0 : mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short watchdog.
// Linear steps, immediate assertions at each comparison.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic        if_err_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic        d_err_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic        mem_err_i;
  logic [31:0] mem_rdata_i;
  logic        mem_abort_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req_i(if_req_i),
    .if_addr_i(if_addr_i),
    .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o),
    .if_err_o(if_err_o),
    .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i),
    .d_we_i(d_we_i),
    .d_be_i(d_be_i),
    .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o),
    .d_err_o(d_err_o),
    .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_err_i(mem_err_i),
    .mem_rdata_i(mem_rdata_i),
    .mem_abort_o(mem_abort_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_d;
    rst = 1'b0;
    if_req_i = 0; if_addr_i = 0;
    d_req_i = 0; d_we_i = 0; d_be_i = 4'hF;
    d_addr_i = 0; d_wdata_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_be", mem_be_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    chk("rst_d_rdata", d_rdata_o, 0);
    chk("rst_abort", mem_abort_o, 0);
    rst = 1'b1;

    // single fetch, zero-latency memory
    if_req_i = 1; if_addr_i = 32'h100;
    #1;
    chk("t1_if_gnt", if_gnt_o, 1);
    chk("t1_d_gnt", d_gnt_o, 0);
    chk("t1_req_c0", mem_req_o, 0);
    step();
    if_req_i = 0;
    #1;
    chk("t1_req_c1", mem_req_o, 1);
    chk("t1_addr", mem_addr_o, 32'h100);
    chk("t1_be", mem_be_o, 4'hF);
    chk("t1_we", mem_we_o, 0);
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    step();
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    #1;
    chk("t1_if_rvalid", if_rvalid_o, 1);
    chk("t1_if_rdata", if_rdata_o, 32'hDEADBEEF);
    chk("t1_d_rvalid", d_rvalid_o, 0);
    chk("t1_busy", busy_o, 0);
    step();
    chk("t1_rvalid_pulse", if_rvalid_o, 0);

    // contention right after reset: data, fetch, data, fetch
    rst = 1'b0;
    #1;
    rst = 1'b1;
    step();
    if_req_i = 1; if_addr_i = 32'h1000;
    d_req_i = 1; d_addr_i = 32'h2000;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      #1;
      chk("t2_d_gnt", d_gnt_o, exp_d);
      chk("t2_if_gnt", if_gnt_o, !exp_d);
      if (k > 0) begin
        chk("t2_d_rvalid", d_rvalid_o, !exp_d);
        chk("t2_if_rvalid", if_rvalid_o, exp_d);
        chk("t2_rdata", exp_d ? if_rdata_o : d_rdata_o, 32'hA0 + k - 1);
      end
      step();
      chk("t2_mem_addr", mem_addr_o, exp_d ? 32'h2000 : 32'h1000);
      if (k == 3) begin
        if_req_i = 0; d_req_i = 0;
      end
      mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hA0 + k;
      step();
      mem_gnt_i = 0; mem_rvalid_i = 0;
    end
    #1;
    chk("t2_last_if_rvalid", if_rvalid_o, 1);
    chk("t2_last_if_rdata", if_rdata_o, 32'hA3);
    chk("t2_last_d_rvalid", d_rvalid_o, 0);
    chk("t2_d_rdata_hold", d_rdata_o, 32'hA2);
    chk("t2_no_gnt", if_gnt_o | d_gnt_o, 0);

    // store with a three-cycle grant stall
    d_req_i = 1; d_we_i = 1; d_be_i = 4'b0011;
    d_addr_i = 32'h2004; d_wdata_i = 32'h1234ABCD;
    #1;
    chk("t3_d_gnt", d_gnt_o, 1);
    step();
    d_req_i = 0; d_we_i = 0; d_be_i = 4'hF;
    d_addr_i = 32'hFFFFFFFF; d_wdata_i = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_req", mem_req_o, 1);
      chk("t3_addr", mem_addr_o, 32'h2004);
      chk("t3_wdata", mem_wdata_o, 32'h1234ABCD);
      chk("t3_be", mem_be_o, 4'b0011);
      chk("t3_we", mem_we_o, 1);
      if (i == 3) mem_gnt_i = 1;
      step();
    end
    mem_gnt_i = 0;
    #1;
    chk("t3_wait_req", mem_req_o, 0);
    chk("t3_wait_busy", busy_o, 1);
    chk("t3_wait_rvalid", d_rvalid_o, 0);
    mem_rvalid_i = 1; mem_rdata_i = 0;
    step();
    mem_rvalid_i = 0;
    chk("t3_d_rvalid", d_rvalid_o, 1);
    chk("t3_d_err", d_err_o, 0);
    step();
    chk("t3_d_rvalid_once", d_rvalid_o, 0);

    // timeout: memory grants and then never answers
    d_req_i = 1; d_addr_i = 32'h3000;
    #1;
    chk("t4_d_gnt", d_gnt_o, 1);
    step();
    d_req_i = 0;
    mem_gnt_i = 1; mem_rdata_i = 32'h55;
    #1;
    chk("t4_abort_c1", mem_abort_o, 0);
    step();
    mem_gnt_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_no_abort", mem_abort_o, 0);
      chk("t4_busy", busy_o, 1);
      step();
    end
    #1;
    chk("t4_abort", mem_abort_o, 1);
    step();
    chk("t4_abort_pulse", mem_abort_o, 0);
    chk("t4_d_rvalid", d_rvalid_o, 1);
    chk("t4_d_err", d_err_o, 1);
    chk("t4_d_rdata", d_rdata_o, 0);
    chk("t4_idle", busy_o, 0);
    mem_rvalid_i = 1; mem_rdata_i = 32'h77;
    step();
    mem_rvalid_i = 0;
    chk("t4_late_d", d_rvalid_o, 0);
    chk("t4_late_if", if_rvalid_o, 0);
    chk("t4_late_rdata", d_rdata_o, 0);

    // memory error on a fetch, then a clean fetch
    if_req_i = 1; if_addr_i = 32'h400;
    #1;
    chk("t5_if_gnt", if_gnt_o, 1);
    step();
    if_req_i = 0; mem_gnt_i = 1;
    step();
    mem_gnt_i = 0;
    mem_rvalid_i = 1; mem_err_i = 1; mem_rdata_i = 32'hBAD;
    step();
    mem_rvalid_i = 0; mem_err_i = 0;
    chk("t5_if_rvalid", if_rvalid_o, 1);
    chk("t5_if_err", if_err_o, 1);
    chk("t5_if_rdata", if_rdata_o, 32'hBAD);
    chk("t5_d_rvalid", d_rvalid_o, 0);
    if_req_i = 1; if_addr_i = 32'h404;
    #1;
    chk("t5_if_gnt2", if_gnt_o, 1);
    step();
    if_req_i = 0;
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h600D;
    step();
    mem_gnt_i = 0; mem_rvalid_i = 0;
    chk("t5_if_rvalid2", if_rvalid_o, 1);
    chk("t5_if_err2", if_err_o, 0);
    chk("t5_if_rdata2", if_rdata_o, 32'h600D);

    // asynchronous reset while waiting on a data read
    d_req_i = 1; d_addr_i = 32'h5000;
    #1;
    chk("t6_d_gnt", d_gnt_o, 1);
    step();
    d_req_i = 0;
    chk("t6_issue_req", mem_req_o, 1);
    mem_gnt_i = 1;
    step();
    mem_gnt_i = 0;
    #2;
    chk("t6_wait_busy", busy_o, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_req", mem_req_o, 0);
    chk("t6_rst_addr", mem_addr_o, 0);
    mem_rvalid_i = 1; mem_rdata_i = 32'h99;
    step();
    #2;
    rst = 1'b1;
    step();
    chk("t6_no_d_rvalid", d_rvalid_o, 0);
    chk("t6_no_if_rvalid", if_rvalid_o, 0);
    chk("t6_d_rdata", d_rdata_o, 0);
    mem_rvalid_i = 0;
    if_req_i = 1; d_req_i = 1;
    #1;
    chk("t6_d_wins", d_gnt_o, 1);
    chk("t6_if_loses", if_gnt_o, 0);
    step();
    if_req_i = 0; d_req_i = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
